// File: rtl/boot_bus_ctrl.sv
// boot_bus_ctrl: CPU read/write bus controller for the 8080-style computer.
// With BOOT_OVERLAY_EN defined, the first three CPU reads return a JMP BOOT_VEC
// opcode stream. After that, every access is decoded to the boot ROM (upper
// pages) or to RAM, with per-target wait states and a level ready handshake.
// With BOOT_OVERLAY_EN undefined, the controller starts decoding straight out of reset.
module boot_bus_ctrl #(
    parameter logic [15:0] BOOT_VEC = 16'hFD00,
    parameter int unsigned ROM_WAIT = 2,
    parameter int unsigned RAM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_ready,
    output logic        rom_rd,
    input  logic [7:0]  rom_data,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [7:0]  ram_data,
    output logic        boot_active
);

    localparam logic [2:0] StIdle = 3'd3;
    localparam logic [2:0] StWait = 3'd4;
    localparam logic [2:0] StHold = 3'd5;
`ifdef BOOT_OVERLAY_EN
    localparam logic [2:0] StB0    = 3'd0;
    localparam logic [2:0] StB1    = 3'd1;
    localparam logic [2:0] StB2    = 3'd2;
    localparam logic [2:0] StReset = StB0;
`else
    localparam logic [2:0] StReset = StIdle;
`endif

    localparam logic [2:0] RomWaitCnt = 3'(ROM_WAIT);
    localparam logic [2:0] RamWaitCnt = 3'(RAM_WAIT);

    logic [2:0] state_q, state_d;
    logic [2:0] ret_q, ret_d;       // state to resume once the CPU releases cpu_rd
    logic [2:0] cnt_q, cnt_d;
    logic       sel_rom_q, sel_rom_d;
    logic [7:0] din_q, din_d;
    logic       ready_q, ready_d;
    logic       rom_rd_q, rom_rd_d;
    logic       ram_rd_q, ram_rd_d;
    logic       ram_wr_q, ram_wr_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
`ifdef BOOT_OVERLAY_EN
    logic       boot_q, boot_d;
`endif

    logic rd_edge;
    logic wr_edge;
    logic rom_region;
    logic unused_addr_lo;

    assign rd_edge    = cpu_rd & ~rd_q;
    assign wr_edge    = cpu_wr & ~wr_q;
    assign rom_region = (cpu_addr[15:8] >= BOOT_VEC[15:8]);
    // Only the page number takes part in decode.
    assign unused_addr_lo = ^cpu_addr[7:0];

    // Next-state logic: overlay, decode, wait countdown and ready handshake.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        sel_rom_d = sel_rom_q;
        din_d     = din_q;
        ready_d   = ready_q;
        rom_rd_d  = 1'b0;
        ram_rd_d  = 1'b0;
        ram_wr_d  = 1'b0;
        rd_d      = cpu_rd;
        wr_d      = cpu_wr;
`ifdef BOOT_OVERLAY_EN
        boot_d    = boot_q;
`endif
        case (state_q)
`ifdef BOOT_OVERLAY_EN
            StB0: begin
                if (rd_edge) begin
                    din_d   = 8'hC3;
                    ready_d = 1'b1;
                    ret_d   = StB1;
                    state_d = StHold;
                end
            end
            StB1: begin
                if (rd_edge) begin
                    din_d   = BOOT_VEC[7:0];
                    ready_d = 1'b1;
                    ret_d   = StB2;
                    state_d = StHold;
                end
            end
            StB2: begin
                if (rd_edge) begin
                    din_d   = BOOT_VEC[15:8];
                    ready_d = 1'b1;
                    ret_d   = StIdle;
                    state_d = StHold;
                end
            end
`endif
            StIdle: begin
                // A read wins over a simultaneous write.
                if (rd_edge) begin
                    sel_rom_d = rom_region;
                    if (rom_region) begin
                        rom_rd_d = 1'b1;
                        cnt_d    = RomWaitCnt;
                    end else begin
                        ram_rd_d = 1'b1;
                        cnt_d    = RamWaitCnt;
                    end
                    state_d = StWait;
                end else if (wr_edge && !rom_region) begin
                    ram_wr_d = 1'b1;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    din_d   = sel_rom_q ? rom_data : ram_data;
                    ready_d = 1'b1;
                    ret_d   = StIdle;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StHold: begin
                if (!cpu_rd) begin
                    ready_d = 1'b0;
                    state_d = ret_q;
`ifdef BOOT_OVERLAY_EN
                    if (ret_q == StIdle) begin
                        boot_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = StReset;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StReset;
            ret_q     <= StIdle;
            cnt_q     <= 3'd0;
            sel_rom_q <= 1'b0;
            din_q     <= 8'h00;
            ready_q   <= 1'b0;
            rom_rd_q  <= 1'b0;
            ram_rd_q  <= 1'b0;
            ram_wr_q  <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
`ifdef BOOT_OVERLAY_EN
            boot_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            sel_rom_q <= sel_rom_d;
            din_q     <= din_d;
            ready_q   <= ready_d;
            rom_rd_q  <= rom_rd_d;
            ram_rd_q  <= ram_rd_d;
            ram_wr_q  <= ram_wr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
`ifdef BOOT_OVERLAY_EN
            boot_q    <= boot_d;
`endif
        end
    end

    assign cpu_din   = din_q;
    assign cpu_ready = ready_q;
    assign rom_rd    = rom_rd_q;
    assign ram_rd    = ram_rd_q;
    assign ram_wr    = ram_wr_q;
`ifdef BOOT_OVERLAY_EN
    assign boot_active = boot_q;
`else
    assign boot_active = 1'b0;
`endif

endmodule

// File: tb/tb_boot_bus_ctrl.sv
// tb_boot_bus_ctrl: directed and randomized bench for boot_bus_ctrl.
// A transaction-level model runs alongside the DUT and every output is compared
// on every cycle. Directed reads and writes pin the model with literal values.
module tb_boot_bus_ctrl;

    localparam logic [15:0] BootVec = 16'hFD00;
    localparam logic [7:0]  RomPage = BootVec[15:8];
    localparam int RomWait = 2;
    localparam int RamWait = 0;
`ifdef BOOT_OVERLAY_EN
    localparam int BootReads = 3;
`else
    localparam int BootReads = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_ready;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic        ram_rd;
    logic        ram_wr;
    logic [7:0]  ram_data;
    logic        boot_active;

    int checks = 0;
    int errors = 0;
    bit rand_data = 1'b0;

    boot_bus_ctrl #(
        .BOOT_VEC (BootVec),
        .ROM_WAIT (RomWait),
        .RAM_WAIT (RamWait)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_din     (cpu_din),
        .cpu_ready   (cpu_ready),
        .rom_rd      (rom_rd),
        .rom_data    (rom_data),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_data    (ram_data),
        .boot_active (boot_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit         m_valid = 1'b0;
    bit         m_prev_rd, m_prev_wr;
    bit         m_busy, m_ready, m_rom;
    bit         m_rom_rd, m_ram_rd, m_ram_wr;
    int         m_delay;      // edges left until read data is captured
    int         m_boot_left;  // overlay reads still to be served
    logic [7:0] m_din;

    function automatic logic [7:0] boot_byte(input int idx);
        case (idx)
            0:       return 8'hC3;
            1:       return BootVec[7:0];
            default: return BootVec[15:8];
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit rd_rise, wr_rise, in_rom;
        rd_rise  = cpu_rd && !m_prev_rd;
        wr_rise  = cpu_wr && !m_prev_wr;
        in_rom   = (cpu_addr[15:8] >= RomPage);
        m_rom_rd = 1'b0;
        m_ram_rd = 1'b0;
        m_ram_wr = 1'b0;
        if (reset) begin
            m_valid     = 1'b1;
            m_busy      = 1'b0;
            m_ready     = 1'b0;
            m_din       = 8'h00;
            m_delay     = 0;
            m_boot_left = BootReads;
            m_prev_rd   = 1'b0;
            m_prev_wr   = 1'b0;
            return;
        end
        if (!m_busy) begin
            if (rd_rise) begin
                m_busy = 1'b1;
                if (m_boot_left > 0) begin
                    m_din   = boot_byte(BootReads - m_boot_left);
                    m_ready = 1'b1;
                    m_delay = 0;
                end else begin
                    m_rom = in_rom;
                    if (in_rom) m_rom_rd = 1'b1;
                    else        m_ram_rd = 1'b1;
                    m_delay = (in_rom ? RomWait : RamWait) + 1;
                end
            end else if (wr_rise && m_boot_left == 0 && !in_rom) begin
                m_ram_wr = 1'b1;
            end
        end else if (m_delay > 0) begin
            m_delay--;
            if (m_delay == 0) begin
                m_din   = m_rom ? rom_data : ram_data;
                m_ready = 1'b1;
            end
        end else if (!cpu_rd) begin
            m_ready = 1'b0;
            m_busy  = 1'b0;
            if (m_boot_left > 0) m_boot_left--;
        end
        m_prev_rd = cpu_rd;
        m_prev_wr = cpu_wr;
    endtask

    // Per-cycle compare; inputs only change 1 time unit after the falling edge.
    initial forever begin
        @(negedge clk);
        model_step();
        if (m_valid) begin
            check("cpu_din", 16'(cpu_din), 16'(m_din));
            check("cpu_ready", 16'(cpu_ready), 16'(m_ready));
            check("rom_rd", 16'(rom_rd), 16'(m_rom_rd));
            check("ram_rd", 16'(ram_rd), 16'(m_ram_rd));
            check("ram_wr", 16'(ram_wr), 16'(m_ram_wr));
            check("boot_active", 16'(boot_active), 16'(m_boot_left > 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
        if (rand_data) begin
            rom_data = 8'($urandom);
            ram_data = 8'($urandom);
        end
    endtask

    task automatic do_read(input logic [15:0] addr, input int hold, output logic [7:0] din,
                           output int lat, output int n_rom, output int n_ram);
        lat      = 0;
        n_rom    = 0;
        n_ram    = 0;
        din      = 8'h00;
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (rom_rd) n_rom++;
            if (ram_rd) n_ram++;
            if (cpu_ready) begin
                lat = n;
                din = cpu_din;
            end
        end
        if (lat == 0) check("read_timeout", 16'(cpu_ready), 16'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("ready_held", 16'(cpu_ready), 16'd1);
        end
        cpu_rd = 1'b0;
        tick();
        check("ready_drop", 16'(cpu_ready), 16'd0);
        tick();
    endtask

    task automatic do_write(input logic [15:0] addr, output int n_wr);
        n_wr     = 0;
        cpu_addr = addr;
        cpu_wr   = 1'b1;
        repeat (3) begin
            tick();
            if (ram_wr) n_wr++;
        end
        cpu_wr = 1'b0;
        repeat (2) begin
            tick();
            if (ram_wr) n_wr++;
        end
    endtask

`ifdef BOOT_OVERLAY_EN
    task automatic run_boot();
        logic [7:0] exp_boot [3];
        logic [7:0] din;
        int lat, nr, nm;
        exp_boot[0] = 8'hC3;
        exp_boot[1] = 8'h00;
        exp_boot[2] = 8'hFD;
        for (int i = 0; i < 3; i++) begin
            do_read(16'($urandom), 1, din, lat, nr, nm);
            check("boot_din", 16'(din), 16'(exp_boot[i]));
            check("boot_lat", 16'(lat), 16'd1);
            check("boot_no_strobe", 16'(nr + nm), 16'd0);
            check("boot_flag", 16'(boot_active), 16'(i < 2));
        end
    endtask
`else
    task automatic first_fetch();
        logic [7:0] din;
        int lat, nr, nm;
        check("noboot_flag", 16'(boot_active), 16'd0);
        do_read(16'h0000, 0, din, lat, nr, nm);
        check("fetch0_ram_rd", 16'(nm), 16'd1);
        check("fetch0_rom_rd", 16'(nr), 16'd0);
        check("fetch0_lat", 16'(lat), 16'd2);
        check("fetch0_din", 16'(din), 16'h5A);
        check("noboot_flag_after", 16'(boot_active), 16'd0);
    endtask
`endif

    initial begin
        logic [7:0] din;
        int lat, nr, nm, nw, r;

        reset    = 1'b1;
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        rom_data = 8'hA5;
        ram_data = 8'h5A;
        repeat (3) tick();
        check("rst_din", 16'(cpu_din), 16'h00);
        check("rst_ready", 16'(cpu_ready), 16'd0);
`ifdef BOOT_OVERLAY_EN
        check("rst_boot", 16'(boot_active), 16'd1);
`else
        check("rst_boot", 16'(boot_active), 16'd0);
`endif
        reset = 1'b0;
        tick();

`ifdef BOOT_OVERLAY_EN
        run_boot();
`else
        first_fetch();
`endif

        // ROM read with two wait states.
        do_read(16'hFD00, 0, din, lat, nr, nm);
        check("rom_strobes", 16'(nr), 16'd1);
        check("rom_no_ram", 16'(nm), 16'd0);
        check("rom_lat", 16'(lat), 16'd4);
        check("rom_din", 16'(din), 16'hA5);

        // RAM read, zero wait states, ready held while cpu_rd stays high.
        do_read(16'h1234, 3, din, lat, nr, nm);
        check("ram_strobes", 16'(nm), 16'd1);
        check("ram_lat", 16'(lat), 16'd2);
        check("ram_din", 16'(din), 16'h5A);

        // Writes: RAM accepted, ROM dropped.
        do_write(16'h0010, nw);
        check("wr_ram_cnt", 16'(nw), 16'd1);
        do_write(16'hFE00, nw);
        check("wr_rom_cnt", 16'(nw), 16'd0);

        // Read and write rising together: read wins.
        nw = 0;
        nm = 0;
        lat = 0;
        cpu_addr = 16'h0020;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b1;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            tick();
            if (ram_wr) nw++;
            if (ram_rd) nm++;
            if (cpu_ready) lat = n;
        end
        check("both_ready_lat", 16'(lat), 16'd2);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (2) begin
            tick();
            if (ram_wr) nw++;
        end
        check("both_no_wr", 16'(nw), 16'd0);
        check("both_ram_rd", 16'(nm), 16'd1);

        // Reset in the middle of a ROM wait.
        cpu_addr = 16'hFF10;
        cpu_rd   = 1'b1;
        repeat (2) tick();
        reset  = 1'b1;
        cpu_rd = 1'b0;
        tick();
        check("wrst_ready", 16'(cpu_ready), 16'd0);
        check("wrst_rom_rd", 16'(rom_rd), 16'd0);
        check("wrst_din", 16'(cpu_din), 16'h00);
        reset = 1'b0;
        tick();
`ifdef BOOT_OVERLAY_EN
        run_boot();
`else
        first_fetch();
`endif

        // Randomized traffic; the per-cycle compare process does the checking.
        rand_data = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            if (!cpu_rd && !cpu_wr) begin
                if (r < 45) begin
                    if ($urandom_range(0, 1) == 1)
                        cpu_addr = {8'($urandom_range(253, 255)), 8'($urandom)};
                    else
                        cpu_addr = 16'($urandom);
                    if (r < 30) begin
                        cpu_rd = 1'b1;
                        cpu_wr = ($urandom_range(0, 9) == 0);
                    end else begin
                        cpu_wr = 1'b1;
                    end
                end
            end else if (r < 25) begin
                cpu_rd = 1'b0;
                cpu_wr = 1'b0;
            end
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset  = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
